ma_seq: RTL and testbench

MA_SEQ -- requirements
Module: ma_seq

---
 rtl/ma_seq.sv | 115 +++++++++++
 tb/tb_ma_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_seq.sv
// ma_seq: memory-address sequencer with load/increment and a small
// call/return stack of saved addresses. All outputs are registered.
module ma_seq #(
  parameter int unsigned AW     = 12,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STRIDE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [2:0]                   op,
  input  logic [AW-1:0]                A,
  input  logic                         err_clr,
  output logic [AW-1:0]                MAout,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         wrap,
  output logic                         err
);

  localparam int unsigned   DW      = $clog2(DEPTH + 1);
  localparam int unsigned   IW      = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  logic [AW-1:0] stack [DEPTH];
  logic [AW:0]   inc_sum;
  logic [AW-1:0] ma_next;
  logic [DW-1:0] cnt_next;
  logic          push;
  logic          wrap_next;
  logic          err_set;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;

  // One extra bit captures the carry out of the increment for wrap detection.
  assign inc_sum  = {1'b0, MAout} + (AW + 1)'(STRIDE);
  assign push_idx = IW'(depth_cnt);
  assign pop_idx  = IW'(depth_cnt - DW'(1));

  // Decode the operation into next address, next depth, push and flag events.
  always_comb begin
    ma_next   = MAout;
    cnt_next  = depth_cnt;
    push      = 1'b0;
    wrap_next = 1'b0;
    err_set   = 1'b0;
    if (enable) begin
      case (op)
        OP_LOAD: ma_next = A;
        OP_INC: begin
          ma_next   = inc_sum[AW-1:0];
          wrap_next = inc_sum[AW];
        end
        OP_CALL: begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            push     = 1'b1;
            cnt_next = depth_cnt + DW'(1);
            ma_next  = A;
          end
        end
        OP_RET: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            ma_next  = stack[pop_idx];
            cnt_next = depth_cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural state and status flags; error set takes priority over clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MAout     <= '0;
      depth_cnt <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      MAout     <= ma_next;
      depth_cnt <= cnt_next;
      full      <= (cnt_next == DEPTH_C);
      empty     <= (cnt_next == '0);
      wrap      <= wrap_next;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Saved-address storage; no reset needed since depth_cnt gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack[push_idx] <= inc_sum[AW-1:0];
    end
  end

endmodule

// File: tb/tb_ma_seq.sv
// tb_ma_seq: scoreboard bench for ma_seq (AW=12, DEPTH=4, STRIDE=1).
module tb_ma_seq;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int DW    = 3;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] INC  = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;

  typedef logic [AW+DW+3:0] vec_t;  // {MAout, depth_cnt, full, empty, wrap, err}

  typedef struct {
    logic          rstn;
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic          clr;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] A = '0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] MAout;
  logic [DW-1:0] depth_cnt;
  logic          full;
  logic          empty;
  logic          wrap;
  logic          err;

  ma_seq #(.AW(AW), .DEPTH(DEPTH), .STRIDE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .op        (op),
    .A         (A),
    .err_clr   (err_clr),
    .MAout     (MAout),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;

  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state
  logic [AW-1:0] m_stack [DEPTH];
  logic [AW-1:0] m_ma  = '0;
  int            m_cnt = 0;
  logic          m_err = 1'b0;
  logic          m_wrap = 1'b0;

  function automatic stim_t S(input logic rstn, input logic en, input logic [2:0] o,
                              input logic [AW-1:0] a, input logic clr);
    stim_t s;
    s.rstn = rstn; s.en = en; s.op = o; s.a = a; s.clr = clr;
    return s;
  endfunction

  function automatic vec_t obs();
    return {MAout, depth_cnt, full, empty, wrap, err};
  endfunction

  // Drive one cycle, advance the model, queue the expected outputs, step past the edge.
  task automatic cyc(input stim_t s);
    logic        e_set;
    logic [AW:0] sum;
    e_set = 1'b0;
    rst_n = s.rstn; enable = s.en; op = s.op; A = s.a; err_clr = s.clr;
    m_wrap = 1'b0;
    if (!s.rstn) begin
      m_ma = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (s.en) begin
        case (s.op)
          LOAD: m_ma = s.a;
          INC: begin
            sum = {1'b0, m_ma} + 13'd1;
            m_ma = sum[AW-1:0];
            m_wrap = sum[AW];
          end
          CALL: begin
            if (m_cnt == DEPTH) e_set = 1'b1;
            else begin
              m_stack[m_cnt] = m_ma + 12'd1;
              m_cnt++;
              m_ma = s.a;
            end
          end
          RET: begin
            if (m_cnt == 0) e_set = 1'b1;
            else begin
              m_cnt--;
              m_ma = m_stack[m_cnt];
            end
          end
          default: ;
        endcase
      end
      if (e_set) m_err = 1'b1;
      else if (s.clr) m_err = 1'b0;
    end
    sb.push_back({m_ma, DW'(m_cnt), (m_cnt == DEPTH), (m_cnt == 0), m_wrap, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    stim_t st [2] = '{S(0, 1, LOAD, 12'hFFF, 1), S(0, 1, CALL, 12'h555, 0)};
    for (int i = 0; i < 2; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if (obs() !== {12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_val step %0d: got %h expected %h", i, obs(),
                 {12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_inc();
    vec_t e;
    stim_t st [4] = '{S(1, 1, LOAD, 12'h123, 0), S(1, 1, INC, 12'h0, 0),
                      S(1, 1, INC, 12'h0, 0), S(1, 1, INC, 12'h0, 0)};
    logic [AW-1:0] ema [4] = '{12'h123, 12'h124, 12'h125, 12'h126};
    for (int i = 0; i < 4; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL inc_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if ({MAout, wrap, empty} !== {ema[i], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL inc_val step %0d: got MAout=%h wrap=%b empty=%b expected MAout=%h wrap=0 empty=1",
                 i, MAout, wrap, empty, ema[i]);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t e;
    stim_t st [5] = '{S(1, 1, LOAD, 12'hFFE, 0), S(1, 1, INC, 12'h0, 0),
                      S(1, 1, INC, 12'h0, 0), S(1, 1, HOLD, 12'h0, 0),
                      S(1, 0, INC, 12'h0, 0)};
    logic [AW-1:0] ema [5] = '{12'hFFE, 12'hFFF, 12'h000, 12'h000, 12'h000};
    logic          ewr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL wrap_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if ({MAout, wrap} !== {ema[i], ewr[i]}) begin
        n_fail++;
        $display("FAIL wrap_val step %0d: got MAout=%h wrap=%b expected MAout=%h wrap=%b",
                 i, MAout, wrap, ema[i], ewr[i]);
      end
    end
  endtask

  task automatic test_stack();
    vec_t e;
    stim_t st [11] = '{S(0, 0, HOLD, 12'h0, 0), S(1, 1, LOAD, 12'h010, 0),
                       S(1, 1, CALL, 12'h100, 0), S(1, 1, CALL, 12'h200, 0),
                       S(1, 1, CALL, 12'h300, 0), S(1, 1, CALL, 12'h400, 0),
                       S(1, 1, CALL, 12'h500, 0), S(1, 1, RET, 12'h0, 0),
                       S(1, 1, RET, 12'h0, 0), S(1, 1, RET, 12'h0, 0),
                       S(1, 1, RET, 12'h0, 0)};
    logic [AW-1:0] ema [11] = '{12'h000, 12'h010, 12'h100, 12'h200, 12'h300, 12'h400,
                                12'h400, 12'h301, 12'h201, 12'h101, 12'h011};
    logic [DW-1:0] ecn [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic          eer [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 11; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stack_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if ({MAout, depth_cnt, err, full} !== {ema[i], ecn[i], eer[i], (ecn[i] == 3'd4)}) begin
        n_fail++;
        $display("FAIL stack_val step %0d: got MAout=%h cnt=%0d err=%b full=%b expected MAout=%h cnt=%0d err=%b",
                 i, MAout, depth_cnt, err, full, ema[i], ecn[i], eer[i]);
      end
    end
  endtask

  task automatic test_err();
    vec_t e;
    stim_t st [4] = '{S(1, 1, HOLD, 12'h0, 1), S(1, 1, RET, 12'h0, 0),
                      S(1, 1, HOLD, 12'h0, 1), S(1, 1, RET, 12'h0, 1)};
    logic eer [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL err_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if ({MAout, empty, err} !== {12'h011, 1'b1, eer[i]}) begin
        n_fail++;
        $display("FAIL err_val step %0d: got MAout=%h empty=%b err=%b expected MAout=011 empty=1 err=%b",
                 i, MAout, empty, err, eer[i]);
      end
    end
  endtask

  task automatic test_enable_reset();
    vec_t e;
    stim_t st [8] = '{S(1, 0, LOAD, 12'hABC, 1), S(1, 0, LOAD, 12'hABC, 0),
                      S(1, 0, LOAD, 12'hABC, 0), S(1, 0, LOAD, 12'hABC, 0),
                      S(1, 0, LOAD, 12'hABC, 0), S(1, 1, CALL, 12'h050, 0),
                      S(0, 1, RET, 12'h0, 0), S(1, 1, RET, 12'h0, 0)};
    logic [AW-1:0] ema [8] = '{12'h011, 12'h011, 12'h011, 12'h011, 12'h011, 12'h050, 12'h000, 12'h000};
    logic [DW-1:0] ecn [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic          eer [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      cyc(st[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL en_rst_sb step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if ({MAout, depth_cnt, err} !== {ema[i], ecn[i], eer[i]}) begin
        n_fail++;
        $display("FAIL en_rst_val step %0d: got MAout=%h cnt=%0d err=%b expected MAout=%h cnt=%0d err=%b",
                 i, MAout, depth_cnt, err, ema[i], ecn[i], eer[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t  e;
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = S(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), AW'($urandom()), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) s.op = (m_cnt < 2) ? CALL : RET;
      cyc(s);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL b2b step %0d: got %h expected %h", i, obs(), e);
      end
      n_chk++;
      if (full && empty) begin
        n_fail++;
        $display("FAIL b2b_fe step %0d: got full=1 empty=1 expected not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_stack();
    test_err();
    test_enable_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
